mem_port_arbiter: RTL

- Shares the single data-memory port (DPI-C pmem read/write path) between instruction fetch (IFU) and load/store (LSU).
- Arbitrates requests, serialises one outstanding transaction at a time, and routes the response back to the owner.
- Sits between the IFU/LSU stages and the memory access block. The memory side uses a valid/ready request channel and a response-valid pulse, so multi-cycle memory latency is supported.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store,
// keeping a single transaction in flight and routing the response back to its owner.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8,
    parameter int RR_EN  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
    localparam logic OWN_IFU = 1'b0, OWN_LSU = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d, last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              ifu_rv_q, ifu_rv_d, lsu_rv_q, lsu_rv_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
    logic              idle, lsu_win, ifu_win, done;

    // On a tie the LSU wins unless round-robin is enabled and the LSU was served last.
    assign idle    = state_q == IDLE;
    assign lsu_win = lsu_req_valid && (!ifu_req_valid || RR_EN == 0 || last_q == OWN_IFU);
    assign ifu_win = ifu_req_valid && !lsu_win;
    assign done    = state_q == WAIT && mem_resp_valid;

    assign ifu_req_ready  = idle && ifu_win;
    assign lsu_req_ready  = idle && lsu_win;
    assign mem_req_valid  = state_q == REQ;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign ifu_resp_valid = ifu_rv_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_resp_valid = lsu_rv_q;
    assign lsu_rdata      = lsu_rdata_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ifu_rv_d    = done && owner_q == OWN_IFU;
        lsu_rv_d    = done && owner_q == OWN_LSU;
        ifu_rdata_d = ifu_rv_d ? mem_rdata : ifu_rdata_q;
        lsu_rdata_d = lsu_rv_d ? (wen_q ? '0 : mem_rdata) : lsu_rdata_q;
        if (idle && (ifu_win || lsu_win)) begin
            state_d = REQ;
            owner_d = lsu_win;
            last_d  = lsu_win;
            addr_d  = lsu_win ? lsu_addr : ifu_addr;
            wen_d   = lsu_win && lsu_wen;
            wdata_d = lsu_win ? lsu_wdata : '0;
            wmask_d = wen_d ? lsu_wmask : '0;
        end else if (state_q == REQ && mem_req_ready) begin
            state_d = WAIT;
        end else if (done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IFU;
            last_q      <= OWN_LSU;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rv_q    <= 1'b0;
            lsu_rv_q    <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rv_q    <= ifu_rv_d;
            lsu_rv_q    <= lsu_rv_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end
endmodule
